pipe_ex_mem_p: RTL

Parametrised EX/MEM pipeline register for the five-stage core. Registers the EX-stage writeback request (register address, write enable, data, valid) into the MEM stage. Also carries the multi-cycle accumulate state (partial HI/LO product and step counter) back to EX. Adds stall, bubble insertion and flush, which the plain pass-through EX register lacks. The HI/LO writeback path is optional.

---
 rtl/pipe_ex_mem_p.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_ex_mem_p.sv
// pipe_ex_mem_p: EX/MEM pipeline register with stall, bubble and flush.
//
// Registers the EX-stage writeback request into the MEM stage and carries the
// multi-cycle accumulate state (acc_tmp/acc_cnt) back to EX.
//
// Priority on each rising clk edge:
//   reset_n low (async) > flush > bubble > hold > advance.
//   bubble  : stall[STAGE]=1, stall[STAGE+1]=0 -> mem_* cleared, acc state tracks EX
//   hold    : stall[STAGE]=1, stall[STAGE+1]=1 -> everything frozen
//   advance : stall[STAGE]=0                    -> mem_* <= ex_*, acc state cleared
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   stall[STALL_W], flush              pipeline control
//   ex_valid/ex_waddr/ex_wen/ex_wdata  EX writeback request
//   ex_acc_tmp/ex_acc_cnt              EX accumulate progress
//   mem_valid/mem_waddr/mem_wen/mem_wdata  registered writeback request
//   acc_tmp_o/acc_cnt_o                accumulate state fed back to EX
//
// Optional feature (macro PIPE_EX_MEM_HILO_EN): adds ex_whilo/ex_hi/ex_lo
// inputs and mem_whilo/mem_hi/mem_lo registered outputs.

module pipe_ex_mem_p #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned STAGE   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [ADDR_W-1:0]     ex_waddr,
    input  logic                  ex_wen,
    input  logic [DATA_W-1:0]     ex_wdata,
`ifdef PIPE_EX_MEM_HILO_EN
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
`endif
    input  logic [2*DATA_W-1:0]   ex_acc_tmp,
    input  logic [1:0]            ex_acc_cnt,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
`ifdef PIPE_EX_MEM_HILO_EN
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
`endif
    output logic [2*DATA_W-1:0]   acc_tmp_o,
    output logic [1:0]            acc_cnt_o
);

    localparam int unsigned ACC_W = 2 * DATA_W;

    logic                r_valid;
    logic [ADDR_W-1:0]   r_waddr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
`ifdef PIPE_EX_MEM_HILO_EN
    logic                r_whilo;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
`endif
    logic [ACC_W-1:0]    r_acc_tmp;
    logic [1:0]          r_acc_cnt;

    // Only this stage's stall bit and the next stage's bit matter.
    logic w_stall_here;
    logic w_stall_next;

    assign w_stall_here = stall[STAGE];
    assign w_stall_next = stall[STAGE+1];

    // Single register bank with reset > flush > bubble > hold > advance priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_waddr   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
`ifdef PIPE_EX_MEM_HILO_EN
            r_whilo   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`endif
            r_acc_tmp <= '0;
            r_acc_cnt <= '0;
        end else if (flush) begin
            // Abandons any in-progress accumulate as well.
            r_valid   <= 1'b0;
            r_waddr   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
`ifdef PIPE_EX_MEM_HILO_EN
            r_whilo   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`endif
            r_acc_tmp <= '0;
            r_acc_cnt <= '0;
        end else if (w_stall_here && !w_stall_next) begin
            // Bubble into MEM while the stalled EX keeps its accumulate progress.
            r_valid   <= 1'b0;
            r_waddr   <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
`ifdef PIPE_EX_MEM_HILO_EN
            r_whilo   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`endif
            r_acc_tmp <= ex_acc_tmp;
            r_acc_cnt <= ex_acc_cnt;
        end else if (!w_stall_here) begin
            // Advance: accumulate is complete once EX moves on.
            r_valid   <= ex_valid;
            r_waddr   <= ex_waddr;
            r_wen     <= ex_wen;
            r_wdata   <= ex_wdata;
`ifdef PIPE_EX_MEM_HILO_EN
            r_whilo   <= ex_whilo;
            r_hi      <= ex_hi;
            r_lo      <= ex_lo;
`endif
            r_acc_tmp <= '0;
            r_acc_cnt <= '0;
        end
        // Remaining case (both stall bits set) holds every register.
    end

    assign mem_valid = r_valid;
    assign mem_waddr = r_waddr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
`ifdef PIPE_EX_MEM_HILO_EN
    assign mem_whilo = r_whilo;
    assign mem_hi    = r_hi;
    assign mem_lo    = r_lo;
`endif
    assign acc_tmp_o = r_acc_tmp;
    assign acc_cnt_o = r_acc_cnt;

endmodule
